// File: rtl/wb_burst_writer.sv
// Wishbone burst write master: turns a (start address, word count) command plus a
// valid/ready word stream into stall-free incrementing-address Wishbone write bursts.
module wb_burst_writer #(
    parameter int dw         = 32,
    parameter int aw         = 8,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [aw-1:0]    cmd_adr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [dw-1:0]    s_data_i,
    output logic             done_o,
    output logic             err_o,
    output logic [aw-1:0]    wb_adr_o,
    output logic [dw-1:0]    wb_dat_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic [1:0]       wb_bte_o,
    output logic [2:0]       wb_cti_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic [dw-1:0]    wb_dat_i
);

    localparam int BL_LOG = $clog2(BURST_LEN);
    localparam int BLW    = BL_LOG + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CW     = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_BURST = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [aw-1:0]    adr_q;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] acc_q;
    logic [BLW-1:0]   beat_q;
    logic             cyc_q;
    logic [2:0]       cti_q;
    logic             err_q;

    logic [dw-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             cmd_fire, start_burst, abort, last_ack;
    logic             push, pop, active;
    logic [BLW-1:0]   to_bnd, blen;

    logic             unused_bits;
    assign unused_bits = ^{wb_dat_i, cmd_adr_i[1:0]};

    // A burst never crosses a BURST_LEN-word aligned boundary and never exceeds what is left.
    always_comb begin
        to_bnd = BLW'(BURST_LEN) - {1'b0, adr_q[2 +: BL_LOG]};
        blen   = (rem_q < LEN_W'(to_bnd)) ? rem_q[BLW-1:0] : to_bnd;
    end

    always_comb begin
        state_d     = state_q;
        cmd_fire    = 1'b0;
        start_burst = 1'b0;
        abort       = 1'b0;
        last_ack    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    cmd_fire = 1'b1;
                    state_d  = (cmd_len_i == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (count_q >= CW'(blen)) begin
                    start_burst = 1'b1;
                    state_d     = S_BURST;
                end
            end
            S_BURST: begin
                if (wb_err_i) begin
                    abort   = 1'b1;
                    state_d = S_DONE;
                end else if (wb_ack_i && beat_q == BLW'(1)) begin
                    last_ack = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_GAP:   state_d = (rem_q == '0) ? S_DONE : S_FILL;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Handshakes: a command transfers on a clock edge where cmd_valid_i && cmd_ready_o, a
    // stream word where s_valid_i && s_ready_o; both readies depend on registered state only.
    assign active      = (state_q == S_FILL) || (state_q == S_BURST) || (state_q == S_GAP);
    assign cmd_ready_o = (state_q == S_IDLE);
    assign s_ready_o   = active && (count_q != CW'(FIFO_DEPTH)) && (acc_q != '0);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;

    assign push = s_valid_i && s_ready_o;
    assign pop  = (state_q == S_BURST) && wb_ack_i && !wb_err_i;

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q;
    assign wb_sel_o = 4'hF;
    assign wb_bte_o = 2'b00;
    assign wb_cti_o = cti_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = cyc_q ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            adr_q  <= '0;
            rem_q  <= '0;
            acc_q  <= '0;
            beat_q <= '0;
            cyc_q  <= 1'b0;
            cti_q  <= 3'b000;
            err_q  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                adr_q <= {cmd_adr_i[aw-1:2], 2'b00};
                rem_q <= cmd_len_i;
                acc_q <= cmd_len_i;
                err_q <= 1'b0;
            end
            if (push) acc_q <= acc_q - 1'b1;
            if (start_burst) begin
                beat_q <= blen;
                cyc_q  <= 1'b1;
                cti_q  <= (blen == BLW'(1)) ? 3'b111 : 3'b010;
            end
            if (pop) begin
                adr_q  <= adr_q + aw'(4);
                rem_q  <= rem_q - 1'b1;
                beat_q <= beat_q - 1'b1;
                cti_q  <= (beat_q == BLW'(2)) ? 3'b111 : 3'b010;
            end
            if (last_ack) begin
                cyc_q <= 1'b0;
                cti_q <= 3'b000;
            end
            // An error ack cancels everything still owed, including words not yet streamed.
            if (abort) begin
                cyc_q <= 1'b0;
                cti_q <= 3'b000;
                err_q <= 1'b1;
                acc_q <= '0;
                rem_q <= '0;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= s_data_i;
    end

endmodule
